// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store engine and MEM/WB pipeline register.
//   clk, rst (async, active-low); mem_* : instruction from EX/MEM;
//   flush : kill current instruction; stallreq : hold upstream stages;
//   dreq_* : data-memory request (valid/ready); dresp_* : load response;
//   wb_* : registered write-back fields.
//   Optional macro MEM_ALIGN_CHECK_EN enables misaligned-access detection (wb_ale).
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic        mem_inst_valid,
   input  logic [31:0] mem_inst_pc,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_mem_addr,
   input  logic [31:0] mem_reg2,
   input  logic [1:0]  mem_excepttype,
   input  logic        flush,
   output logic        stallreq,
   output logic        dreq_valid,
   input  logic        dreq_ready,
   output logic        dreq_we,
   output logic [31:0] dreq_addr,
   output logic [3:0]  dreq_wstrb,
   output logic [31:0] dreq_wdata,
   input  logic        dresp_valid,
   input  logic [31:0] dresp_rdata,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        wb_inst_valid,
   output logic [31:0] wb_inst_pc,
   output logic [1:0]  wb_excepttype,
   output logic        wb_ale
);
   localparam logic [7:0] EXE_LD_B_OP  = 8'h20;
   localparam logic [7:0] EXE_LD_H_OP  = 8'h21;
   localparam logic [7:0] EXE_LD_W_OP  = 8'h22;
   localparam logic [7:0] EXE_LD_BU_OP = 8'h23;
   localparam logic [7:0] EXE_LD_HU_OP = 8'h24;
   localparam logic [7:0] EXE_ST_B_OP  = 8'h25;
   localparam logic [7:0] EXE_ST_H_OP  = 8'h26;
   localparam logic [7:0] EXE_ST_W_OP  = 8'h27;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t state, state_nx;
   logic [31:0] addr_q, wdata_q, wdata_c, ld_shift, ld_data;
   logic [3:0]  wstrb_q, wstrb_c;
   logic [7:0]  aluop_q;
   logic [15:0] ld_half;
   logic        we_q, kill_q, is_load, is_store, is_mem, ale, issue, load_done, bubble;

   assign is_load  = mem_aluop inside {EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP, EXE_LD_BU_OP, EXE_LD_HU_OP};
   assign is_store = mem_aluop inside {EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};
   assign is_mem   = mem_inst_valid && (is_load || is_store);
`ifdef MEM_ALIGN_CHECK_EN
   assign ale = is_mem && (((mem_aluop inside {EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP}) && mem_mem_addr[0]) ||
                           ((mem_aluop inside {EXE_LD_W_OP, EXE_ST_W_OP}) && mem_mem_addr[1:0] != 2'b00));
`else
   assign ale = 1'b0;
`endif
   // rst gating keeps every request output quiet while reset is asserted
   assign issue = rst && state == IDLE && is_mem && !flush && !ale;
   assign wstrb_c = mem_aluop == EXE_ST_B_OP ? 4'b0001 << mem_mem_addr[1:0] :
                    mem_aluop == EXE_ST_H_OP ? (mem_mem_addr[1] ? 4'b1100 : 4'b0011) :
                    mem_aluop == EXE_ST_W_OP ? 4'b1111 : 4'b0000;
   assign wdata_c = mem_aluop == EXE_ST_B_OP ? {4{mem_reg2[7:0]}} :
                    mem_aluop == EXE_ST_H_OP ? {2{mem_reg2[15:0]}} :
                    mem_aluop == EXE_ST_W_OP ? mem_reg2 : 32'h0;

   // lane selection uses the address latched at issue, not the live input
   assign ld_shift = dresp_rdata >> {addr_q[1:0], 3'b000};
   assign ld_half  = addr_q[1] ? dresp_rdata[31:16] : dresp_rdata[15:0];
   assign ld_data  = aluop_q == EXE_LD_B_OP  ? {{24{ld_shift[7]}}, ld_shift[7:0]} :
                     aluop_q == EXE_LD_BU_OP ? {24'h0, ld_shift[7:0]} :
                     aluop_q == EXE_LD_H_OP  ? {{16{ld_half[15]}}, ld_half} :
                     aluop_q == EXE_LD_HU_OP ? {16'h0, ld_half} : dresp_rdata;
   assign load_done = state == WAIT && dresp_valid;
   // a killed drain still lets the stage advance, but nothing reaches write-back
   assign bubble = stallreq || flush || kill_q;

   always_comb begin
      state_nx   = state;
      dreq_valid = 1'b0;
      dreq_we    = 1'b0;
      dreq_addr  = 32'h0;
      dreq_wstrb = 4'h0;
      dreq_wdata = 32'h0;
      stallreq   = 1'b0;
      case (state)
         IDLE: if (issue) begin
            dreq_valid = 1'b1;
            dreq_we    = is_store;
            dreq_addr  = {mem_mem_addr[31:2], 2'b00};
            dreq_wstrb = wstrb_c;
            dreq_wdata = wdata_c;
            stallreq   = !dreq_ready || is_load;
            state_nx   = !dreq_ready ? REQ : is_load ? WAIT : IDLE;
         end
         REQ: begin
            dreq_valid = 1'b1;
            dreq_we    = we_q;
            dreq_addr  = {addr_q[31:2], 2'b00};
            dreq_wstrb = wstrb_q;
            dreq_wdata = wdata_q;
            // an accepted store finishes here, so the stage may advance
            stallreq   = !(dreq_ready && we_q);
            state_nx   = !dreq_ready ? REQ : we_q ? IDLE : WAIT;
         end
         WAIT: begin
            stallreq = !dresp_valid;
            state_nx = dresp_valid ? IDLE : WAIT;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         wstrb_q       <= 4'h0;
         we_q          <= 1'b0;
         aluop_q       <= 8'h0;
         kill_q        <= 1'b0;
         wb_wd         <= 5'h0;
         wb_wreg       <= 1'b0;
         wb_wdata      <= 32'h0;
         wb_inst_valid <= 1'b0;
         wb_inst_pc    <= 32'h0;
         wb_excepttype <= 2'h0;
         wb_ale        <= 1'b0;
      end else begin
         state <= state_nx;
         if (issue) begin
            addr_q  <= mem_mem_addr;
            wdata_q <= wdata_c;
            wstrb_q <= wstrb_c;
            we_q    <= is_store;
            aluop_q <= mem_aluop;
         end
         kill_q        <= state_nx == IDLE ? 1'b0 : kill_q || (state != IDLE && flush);
         wb_wd         <= bubble ? 5'h0 : mem_wd;
         wb_wreg       <= bubble ? 1'b0 : mem_wreg && !(is_mem && is_store) && !ale;
         wb_wdata      <= bubble ? 32'h0 : load_done ? ld_data : mem_wdata;
         wb_inst_valid <= bubble ? 1'b0 : mem_inst_valid;
         wb_inst_pc    <= bubble ? 32'h0 : mem_inst_pc;
         wb_excepttype <= bubble ? 2'h0 : mem_excepttype;
         wb_ale        <= bubble ? 1'b0 : ale;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed table-driven and sequence checks for mem_access.
module tb_mem_access;
   localparam logic [7:0] NOP   = 8'h10;
   localparam logic [7:0] LD_B  = 8'h20;
   localparam logic [7:0] LD_H  = 8'h21;
   localparam logic [7:0] LD_W  = 8'h22;
   localparam logic [7:0] LD_BU = 8'h23;
   localparam logic [7:0] LD_HU = 8'h24;
   localparam logic [7:0] ST_B  = 8'h25;
   localparam logic [7:0] ST_H  = 8'h26;
   localparam logic [7:0] ST_W  = 8'h27;

   logic clk = 0, rst = 0;
   logic [4:0] mem_wd = 0;
   logic mem_wreg = 0, mem_inst_valid = 0, flush = 0, dreq_ready = 0, dresp_valid = 0;
   logic [31:0] mem_wdata = 0, mem_inst_pc = 0, mem_mem_addr = 0, mem_reg2 = 0, dresp_rdata = 0;
   logic [7:0] mem_aluop = 0;
   logic [1:0] mem_excepttype = 0;
   logic stallreq, dreq_valid, dreq_we, wb_wreg, wb_inst_valid, wb_ale;
   logic [31:0] dreq_addr, dreq_wdata, wb_wdata, wb_inst_pc;
   logic [3:0] dreq_wstrb;
   logic [4:0] wb_wd;
   logic [1:0] wb_excepttype;
   int n_tests = 0, n_fail = 0;

   mem_access dut (
      .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_inst_valid(mem_inst_valid), .mem_inst_pc(mem_inst_pc), .mem_aluop(mem_aluop),
      .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_excepttype(mem_excepttype),
      .flush(flush), .stallreq(stallreq), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
      .dreq_we(dreq_we), .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
      .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
      .wb_wdata(wb_wdata), .wb_inst_valid(wb_inst_valid), .wb_inst_pc(wb_inst_pc),
      .wb_excepttype(wb_excepttype), .wb_ale(wb_ale)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr, reg2, wdata;
      logic        iv, fl, rdy;
      logic        e_valid, e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_wstrb;
      logic [31:0] e_dw;
      logic        e_stall, e_wreg;
      logic [31:0] e_wb;
      logic        e_iv;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] wdata, input logic iv);
      mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wdata = wdata;
      mem_inst_valid = iv; mem_wd = 5'd5; mem_wreg = 1'b1; mem_inst_pc = 32'h400; mem_excepttype = 2'b10;
   endtask

   task automatic load_seq(input string nm, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input int waits, input logic [31:0] exp);
      int stalls = 0;
      set_op(op, addr, 0, 32'h99, 1);
      for (int c = 0; c <= waits + 1; c++) begin
         dreq_ready = (c == 0);
         dresp_valid = (c == waits + 1);
         dresp_rdata = (c == waits + 1) ? rdata : 32'hDEAD0000;
         @(negedge clk);
         if (stallreq) stalls++;
         if (c == 0) begin
            chk({nm, "_valid"}, {31'b0, dreq_valid}, 1);
            chk({nm, "_we"}, {31'b0, dreq_we}, 0);
            chk({nm, "_addr"}, dreq_addr, {addr[31:2], 2'b00});
         end
         @(posedge clk); #1;
      end
      dreq_ready = 0; dresp_valid = 0;
      chk({nm, "_stalls"}, stalls, waits + 1);
      chk({nm, "_wdata"}, wb_wdata, exp);
      chk({nm, "_wreg"}, {31'b0, wb_wreg}, 1);
      set_op(NOP, 0, 0, 0, 0);
   endtask

   initial begin
      int acc, stalls;
      vecs[0] = '{NOP,  32'h0,    32'h0,        32'h1234, 1, 0, 1, 0, 0, 32'h0,    4'h0,    32'h0,        0, 1, 32'h1234, 1};
      vecs[1] = '{ST_B, 32'h1003, 32'hAB,       32'h55,   1, 0, 1, 1, 1, 32'h1000, 4'b1000, 32'hABABABAB, 0, 0, 32'h55,   1};
      vecs[2] = '{ST_H, 32'h1002, 32'h1234ABCD, 32'h55,   1, 0, 1, 1, 1, 32'h1000, 4'b1100, 32'hABCDABCD, 0, 0, 32'h55,   1};
      vecs[3] = '{ST_H, 32'h1000, 32'h1234ABCD, 32'h66,   1, 0, 1, 1, 1, 32'h1000, 4'b0011, 32'hABCDABCD, 0, 0, 32'h66,   1};
      vecs[4] = '{ST_W, 32'h1004, 32'hDEADBEEF, 32'h77,   1, 0, 1, 1, 1, 32'h1004, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h77,   1};
      vecs[5] = '{ST_B, 32'h1001, 32'h5A,       32'h88,   1, 0, 1, 1, 1, 32'h1000, 4'b0010, 32'h5A5A5A5A, 0, 0, 32'h88,   1};
      vecs[6] = '{ST_W, 32'h1008, 32'h1,        32'h99,   1, 1, 1, 0, 0, 32'h0,    4'h0,    32'h0,        0, 0, 32'h0,    0};
      vecs[7] = '{LD_W, 32'h2000, 32'h0,        32'hAA,   0, 0, 1, 0, 0, 32'h0,    4'h0,    32'h0,        0, 1, 32'hAA,   0};
      vecs[8] = '{NOP,  32'h0,    32'h0,        32'hBB,   1, 1, 1, 0, 0, 32'h0,    4'h0,    32'h0,        0, 0, 32'h0,    0};

      set_op(NOP, 0, 0, 0, 0);
      #12;
      chk("rst_valid", {31'b0, dreq_valid}, 0);
      chk("rst_stall", {31'b0, stallreq}, 0);
      chk("rst_wb_wdata", wb_wdata, 0);
      chk("rst_wb_iv", {31'b0, wb_inst_valid}, 0);
      @(posedge clk); #1 rst = 1;

      for (int i = 0; i < 9; i++) begin
         set_op(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].wdata, vecs[i].iv);
         flush = vecs[i].fl; dreq_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), {31'b0, dreq_valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d_we", i), {31'b0, dreq_we}, {31'b0, vecs[i].e_we});
         chk($sformatf("v%0d_addr", i), dreq_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_wstrb", i), {28'b0, dreq_wstrb}, {28'b0, vecs[i].e_wstrb});
         chk($sformatf("v%0d_dwdata", i), dreq_wdata, vecs[i].e_dw);
         chk($sformatf("v%0d_stall", i), {31'b0, stallreq}, {31'b0, vecs[i].e_stall});
         @(posedge clk); #1;
         chk($sformatf("v%0d_wreg", i), {31'b0, wb_wreg}, {31'b0, vecs[i].e_wreg});
         chk($sformatf("v%0d_wbdata", i), wb_wdata, vecs[i].e_wb);
         chk($sformatf("v%0d_iv", i), {31'b0, wb_inst_valid}, {31'b0, vecs[i].e_iv});
         chk($sformatf("v%0d_pc", i), wb_inst_pc, vecs[i].fl ? 32'h0 : 32'h400);
         chk($sformatf("v%0d_wd", i), {27'b0, wb_wd}, vecs[i].fl ? 32'h0 : 32'h5);
         chk($sformatf("v%0d_exc", i), {30'b0, wb_excepttype}, vecs[i].fl ? 32'h0 : 32'h2);
         chk($sformatf("v%0d_ale", i), {31'b0, wb_ale}, 0);
      end
      flush = 0; dreq_ready = 0;
      set_op(NOP, 0, 0, 0, 0);

      load_seq("ldb", LD_B, 32'h2001, 32'h00008000, 3, 32'hFFFFFF80);
      load_seq("ldbu", LD_BU, 32'h2001, 32'h00008000, 3, 32'h00000080);
      load_seq("ldh", LD_H, 32'h2002, 32'h8001F00D, 1, 32'hFFFF8001);
      load_seq("ldhu", LD_HU, 32'h2000, 32'h1234F00D, 0, 32'h0000F00D);
      load_seq("ldw", LD_W, 32'h2004, 32'hCAFEBABE, 0, 32'hCAFEBABE);

      // store held off by ready=0 for two cycles
      acc = 0; stalls = 0;
      set_op(ST_H, 32'h1006, 32'h0000BEEF, 32'h11, 1);
      for (int c = 0; c < 3; c++) begin
         dreq_ready = (c == 2);
         @(negedge clk);
         if (dreq_valid && dreq_ready) acc++;
         if (stallreq) stalls++;
         chk($sformatf("hold%0d_addr", c), dreq_addr, 32'h1004);
         chk($sformatf("hold%0d_wstrb", c), {28'b0, dreq_wstrb}, 32'hC);
         chk($sformatf("hold%0d_wdata", c), dreq_wdata, 32'hBEEFBEEF);
         if (c == 0) set_op(ST_H, 32'h1006, 32'h0000BEEF, 32'h11, 1);
         @(posedge clk); #1;
      end
      chk("hold_accepts", acc, 1);
      chk("hold_stalls", stalls, 2);
      chk("hold_wb_iv", {31'b0, wb_inst_valid}, 1);
      chk("hold_wb_wreg", {31'b0, wb_wreg}, 0);
      dreq_ready = 0;
      set_op(NOP, 0, 0, 0, 0);
      @(negedge clk);
      chk("hold_after_valid", {31'b0, dreq_valid}, 0);
      @(posedge clk); #1;

      // flush while waiting for a load response
      set_op(LD_W, 32'h2008, 0, 32'h22, 1);
      dreq_ready = 1;
      @(posedge clk); #1 dreq_ready = 0; flush = 1;
      @(negedge clk);
      chk("fwait_stall1", {31'b0, stallreq}, 1);
      @(posedge clk); #1 flush = 0; dresp_valid = 1; dresp_rdata = 32'h12345678;
      @(negedge clk);
      chk("fwait_stall2", {31'b0, stallreq}, 0);
      @(posedge clk); #1 dresp_valid = 0;
      chk("fwait_wreg", {31'b0, wb_wreg}, 0);
      chk("fwait_iv", {31'b0, wb_inst_valid}, 0);
      set_op(NOP, 0, 0, 0, 0);

      // flush while the load request is still pending
      set_op(LD_W, 32'h200C, 0, 32'h33, 1);
      dreq_ready = 0;
      @(posedge clk); #1 flush = 1;
      @(negedge clk);
      chk("freq_valid", {31'b0, dreq_valid}, 1);
      @(posedge clk); #1 flush = 0; dreq_ready = 1;
      @(negedge clk);
      chk("freq_valid2", {31'b0, dreq_valid}, 1);
      chk("freq_stall", {31'b0, stallreq}, 1);
      @(posedge clk); #1 dreq_ready = 0; dresp_valid = 1;
      @(negedge clk);
      chk("freq_stall2", {31'b0, stallreq}, 0);
      @(posedge clk); #1 dresp_valid = 0;
      chk("freq_iv", {31'b0, wb_inst_valid}, 0);
      set_op(NOP, 0, 0, 0, 0);

      // reset while a load is outstanding, then a stale response
      set_op(LD_W, 32'h2010, 0, 32'h44, 1);
      dreq_ready = 1;
      @(posedge clk); #1 dreq_ready = 0;
      set_op(NOP, 0, 0, 0, 0);
      #1 rst = 0;
      @(negedge clk);
      chk("mrst_stall", {31'b0, stallreq}, 0);
      chk("mrst_valid", {31'b0, dreq_valid}, 0);
      @(posedge clk); #1 rst = 1;
      set_op(NOP, 0, 0, 32'h77, 1);
      dresp_valid = 1; dresp_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("stale_stall", {31'b0, stallreq}, 0);
      @(posedge clk); #1 dresp_valid = 0;
      chk("stale_wdata", wb_wdata, 32'h77);
      set_op(NOP, 0, 0, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
      set_op(LD_W, 32'h3002, 0, 32'h55, 1);
      dreq_ready = 1;
      @(negedge clk);
      chk("ale_valid", {31'b0, dreq_valid}, 0);
      chk("ale_stall", {31'b0, stallreq}, 0);
      @(posedge clk); #1 dreq_ready = 0;
      chk("ale_flag", {31'b0, wb_ale}, 1);
      chk("ale_wreg", {31'b0, wb_wreg}, 0);
      chk("ale_iv", {31'b0, wb_inst_valid}, 1);
      set_op(NOP, 0, 0, 0, 0);
`else
      load_seq("misw", LD_W, 32'h3002, 32'hCAFEF00D, 0, 32'hCAFEF00D);
      chk("misw_ale", {31'b0, wb_ale}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
